hex_seg_scanner: RTL
====================

// Module: hex_seg_scanner
// PURPOSE
//  Parametrised address display with auto-scan for the memory-block labs.
//  - Holds an ADDR_W-bit address register and drives NDIG active-low 7-seg hex digits.
//  - MANUAL mode: the register follows addr_in.
//  - AUTO mode: the register steps through every address at a prescaled tick rate,
//    so RAM contents can be swept on the board.
//  - addr_out feeds the RAM read port; seg drives HEXn.
// PARAMETERS
//  ADDR_W    5    address width; 1..16
//  NDIG      2    digits driven; must be >= ceil(ADDR_W/4)
//  TICK_DIV  50_000_000  clk cycles per auto-step; >= 2
// PORTS
//  clk       in   1             system clock; all logic on rising edge
//  reset     in   1             synchronous, active-high
//  auto_en   in   1             1 = scan mode, 0 = manual
//  pause     in   1             freeze scan; ignored when auto_en=0
//  blank_lz  in   1             1 = blank leading zero digits
//  addr_in   in   ADDR_W        manual address / scan start point
//  addr_out  out  ADDR_W        current address register
//  tick      out  1             one-cycle pulse on each scan step
//  seg       out  NDIG x 7      seg[i] = digit i (i=0 is least significant); active-low gfedcba
// BEHAVIOUR
//  Reset (sync, high), next edge:
//   - state=MANUAL, addr_out=0, prescaler=0, tick=0.
//   - every seg[i]=7'h40 ('0'), whatever blank_lz is.
//  State machine (seg7_pkg::scan_state_t): MANUAL, SCAN, PAUSED.
//   - MANUAL -> SCAN on auto_en=1. On this transition addr <= addr_in and prescaler <= 0.
//   - SCAN -> PAUSED on pause=1. The prescaler holds its value.
//   - PAUSED -> SCAN on pause=0. The prescaler resumes from the held count.
//   - Any state -> MANUAL on auto_en=0. This has priority over pause and over tick.
//  MANUAL: addr <= addr_in every cycle (1-cycle latency).
//  Prescaler: runs only in SCAN and counts 0..TICK_DIV-1.
//   - At TICK_DIV-1 it wraps to 0 and tick=1 for exactly that cycle.
//   - tick is registered.
//  SCAN: on each tick cycle addr <= addr+1, modulo 2^ADDR_W. All-ones wraps to 0 with no gap.
//  Simultaneous events:
//   - auto_en falling while the prescaler is at TICK_DIV-1: no increment, no tick pulse.
//   - pause rising in the same cycle: same, no increment and no tick pulse.
//  Display path:
//   - seg is registered from addr_out. Latency addr_out -> seg is 1 cycle.
//   - Latency addr_in -> seg in MANUAL is 2 cycles.
//  Digit i shows nibble addr[4i+3:4i]; bits at or above ADDR_W read as 0.
//   - Encoding: 0..F use the team glyph set; 'b' and 'd' are lower case.
//  Leading-zero blanking (blank_lz=1):
//   - digit i>0 = 7'h7F if all nibbles j>=i are 0.
//   - digit 0 is never blanked.
//  Reset mid-scan: state, addr, prescaler and seg all return to reset values on that edge.
// STRUCTURE
//  Package seg7_pkg:
//   - CHR_0..CHR_F and BLANK constants (7-bit, active-low).
//   - scan_state_t enum.
//  Sub-module hex_to_seg7: combinational 4-bit -> 7-bit decoder, instantiated NDIG times
//   in a generate loop.
//  Top module contents:
//   - prescaler;
//   - FSM;
//   - address register;
//   - blanking mask;
//   - output registers.
// TESTING (bench uses TICK_DIV=4, ADDR_W=5, NDIG=2)
//  1. Reset held 2 cycles, then released with auto_en=0, addr_in=5'h1B.
//     -> at release, seg={40,40} and addr_out=0;
//     -> 2 cycles later, seg={79,03} ("1b").
//  2. Manual, blank_lz=1, addr_in=5'h07 -> seg[1]=7F, seg[0]=58.
//     Then addr_in=5'h10 -> seg={79,40}.
//  3. auto_en=1 with addr_in=5'h1E -> addr_out sequence 1E,1F,00,01.
//     Each step is 4 cycles apart; tick is a 1-cycle pulse at each step.
//  4. In SCAN, pause=1 for 10 cycles -> addr_out and the prescaler are frozen, tick=0.
//     After pause=0 -> the next step arrives after the remaining count, not a full TICK_DIV.
//  5. Drop auto_en on the cycle the prescaler hits 3 -> no increment, tick stays 0.
//     The next cycle has addr_out=addr_in.
//  6. Assert reset mid-SCAN at addr 5'h0C -> next edge: addr_out=0, seg={40,40}, tick=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph constants, scan FSM states and the hex glyph lookup for the
// seven-segment address display.
package seg7_pkg;

    // Active-low gfedcba; 7 includes segment f, 'b' and 'd' are lower case.
    localparam logic [6:0] CHR_0 = 7'h40;
    localparam logic [6:0] CHR_1 = 7'h79;
    localparam logic [6:0] CHR_2 = 7'h24;
    localparam logic [6:0] CHR_3 = 7'h30;
    localparam logic [6:0] CHR_4 = 7'h19;
    localparam logic [6:0] CHR_5 = 7'h12;
    localparam logic [6:0] CHR_6 = 7'h02;
    localparam logic [6:0] CHR_7 = 7'h58;
    localparam logic [6:0] CHR_8 = 7'h00;
    localparam logic [6:0] CHR_9 = 7'h10;
    localparam logic [6:0] CHR_A = 7'h08;
    localparam logic [6:0] CHR_B = 7'h03;
    localparam logic [6:0] CHR_C = 7'h46;
    localparam logic [6:0] CHR_D = 7'h21;
    localparam logic [6:0] CHR_E = 7'h06;
    localparam logic [6:0] CHR_F = 7'h0E;
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {
        StManual,
        StScan,
        StPaused
    } scan_state_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = CHR_0;
            4'h1: g = CHR_1;
            4'h2: g = CHR_2;
            4'h3: g = CHR_3;
            4'h4: g = CHR_4;
            4'h5: g = CHR_5;
            4'h6: g = CHR_6;
            4'h7: g = CHR_7;
            4'h8: g = CHR_8;
            4'h9: g = CHR_9;
            4'hA: g = CHR_A;
            4'hB: g = CHR_B;
            4'hC: g = CHR_C;
            4'hD: g = CHR_D;
            4'hE: g = CHR_E;
            default: g = CHR_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-low seven-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = hex_glyph(hex_i);
    end

endmodule

// File: rtl/hex_seg_scanner.sv
// Address register with manual/auto-scan control, driving NDIG registered
// hex digits with optional leading-zero blanking.
module hex_seg_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NDIG     = 2,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                auto_en,
    input  logic                pause,
    input  logic                blank_lz,
    input  logic [ADDR_W-1:0]   addr_in,
    output logic [ADDR_W-1:0]   addr_out,
    output logic                tick,
    output logic [NDIG*7-1:0]   seg
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam int unsigned NIB_W = 4 * NDIG;

    scan_state_t           state_q, state_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  tick_q, tick_d;
    logic [NDIG*7-1:0]     seg_q, seg_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StManual;
            presc_q <= '0;
            addr_q  <= '0;
            tick_q  <= 1'b0;
            seg_q   <= {NDIG{CHR_0}};
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            addr_q  <= addr_d;
            tick_q  <= tick_d;
            seg_q   <= seg_d;
        end
    end

    // Dropping auto_en wins over pause and over a pending wrap.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        addr_d  = addr_q;
        tick_d  = 1'b0;
        if (!auto_en) begin
            state_d = StManual;
            addr_d  = addr_in;
            presc_d = '0;
        end else begin
            unique case (state_q)
                StManual: begin
                    state_d = StScan;
                    addr_d  = addr_in;
                    presc_d = '0;
                end
                StScan: begin
                    if (pause) begin
                        state_d = StPaused;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        addr_d  = addr_q + ADDR_W'(1);
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                StPaused: begin
                    if (!pause) begin
                        state_d = StScan;
                    end
                end
                default: state_d = StManual;
            endcase
        end
    end

    // Display path: nibbles above ADDR_W read as zero.
    logic [NIB_W-1:0] addr_ext;
    logic [6:0]       glyph [NDIG];
    logic [NDIG-1:0]  blank;
    logic             upper_nz;

    assign addr_ext = NIB_W'(addr_q);

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        hex_to_seg7 u_dec (
            .hex_i (addr_ext[4*i +: 4]),
            .seg_o (glyph[i])
        );
    end

    // Walk from the top digit down; a digit blanks while nothing above or at it is set.
    always_comb begin
        blank    = '0;
        upper_nz = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            upper_nz = upper_nz | (|addr_ext[4*i +: 4]);
            blank[i] = blank_lz && (i > 0) && !upper_nz;
        end
    end

    always_comb begin
        seg_d = '0;
        for (int i = 0; i < NDIG; i++) begin
            seg_d[7*i +: 7] = blank[i] ? BLANK : glyph[i];
        end
    end

    assign addr_out = addr_q;
    assign tick     = tick_q;
    assign seg      = seg_q;

endmodule
